// File: rtl/lu_pkg.sv
// ============================================================================
//  Module   : lu_pkg
//  Purpose  : Shared types and constants for the lu_arbiter logic-unit slice.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lu_pkg;

    localparam int LU_DATA_W   = 3;
    localparam int LU_ID_MAX_W = 3;

    typedef enum logic [1:0] {
        LU_ZERO = 2'b00,
        LU_AND  = 2'b01,
        LU_OR   = 2'b10,
        LU_XOR  = 2'b11
    } lu_op_e;

    typedef struct packed {
        logic [LU_ID_MAX_W-1:0] id;
        logic [LU_DATA_W-1:0]   data;
    } lu_rsp_t;

endpackage : lu_pkg

`default_nettype wire

// File: rtl/lu_core.sv
// ============================================================================
//  Module   : lu_core
//  Purpose  : Combinational logic unit: zero / AND / OR / XOR of two operands.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lu_core
    import lu_pkg::*;
#(
    parameter int DATA_W = LU_DATA_W
) (
    input  lu_op_e            op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            LU_ZERO: res_o = '0;
            LU_AND:  res_o = a_i & b_i;
            LU_OR:   res_o = a_i | b_i;
            LU_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

endmodule : lu_core

`default_nettype wire

// File: rtl/lu_arbiter.sv
// ============================================================================
//  Module   : lu_arbiter
//  Purpose  : Round-robin arbiter sharing one lu_core among NUM_REQ requesters,
//             with a single registered valid/ready response channel.
//             Optional macro LU_ARBITER_STALL_CNT_EN adds a saturating
//             16-bit response-stall counter on stall_cnt_o.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lu_arbiter
    import lu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = LU_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*2-1:0]      req_op_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o,
`ifdef LU_ARBITER_STALL_CNT_EN
    output logic [15:0]               stall_cnt_o,
`endif
    input  logic                      rsp_ready_i
);

    localparam int IDX_W = ID_W + 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    ptr_inc;
    logic                can_accept;
    logic                grant;
    lu_op_e              win_op;
    logic [DATA_W-1:0]   win_a;
    logic [DATA_W-1:0]   win_b;
    logic [DATA_W-1:0]   win_res;

    // Search rr_ptr, rr_ptr+1, ... with an explicit wrap so non power-of-2
    // NUM_REQ never indexes past the last requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (cand >= IDX_W'(NUM_REQ)) begin
                cand = cand - IDX_W'(NUM_REQ);
            end
            if (!win_found && req_valid_i[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign can_accept  = (state_q == ST_EMPTY) || rsp_ready_i;
    assign grant       = win_found && can_accept && !rst_i;
    assign req_ready_o = grant ? (NUM_REQ'(1) << win_idx) : '0;

    assign win_op = lu_op_e'(req_op_i[{win_idx, 1'b0} +: 2]);
    assign win_a  = req_a_i[int'(win_idx)*DATA_W +: DATA_W];
    assign win_b  = req_b_i[int'(win_idx)*DATA_W +: DATA_W];

    lu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op_i  (win_op),
        .a_i   (win_a),
        .b_i   (win_b),
        .res_o (win_res)
    );

    always_comb begin
        ptr_inc = {1'b0, win_idx} + IDX_W'(1);
        if (ptr_inc == IDX_W'(NUM_REQ)) begin
            ptr_inc = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (grant) begin
            rr_ptr_d   = ptr_inc[ID_W-1:0];
            rsp_id_d   = win_idx;
            rsp_data_d = win_res;
        end
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL:  if (!grant && rsp_ready_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

`ifdef LU_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_FULL) && !rsp_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : lu_arbiter

`default_nettype wire

// File: tb/tb_lu_arbiter.sv
// ============================================================================
//  Module   : tb_lu_arbiter
//  Purpose  : Scoreboard bench for lu_arbiter with a queue-based reference.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lu_arbiter;

    localparam int N  = 4;
    localparam int DW = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;
`ifdef LU_ARBITER_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    lu_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
`ifdef LU_ARBITER_STALL_CNT_EN
        .stall_cnt_o (stall_cnt),
`endif
        .rsp_ready_i (rsp_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   m_full  = 0;
    int   m_ptr   = 0;
    int   m_stall = 0;

    int v[N];
    int op[N];
    int a[N];
    int b[N];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int ref_op(input int o, input int x, input int y);
        case (o)
            1:       return x & y;
            2:       return x | y;
            3:       return x ^ y;
            default: return 0;
        endcase
    endfunction

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = v[k][0];
            req_op[2*k +: 2]      = op[k][1:0];
            req_a[DW*k +: DW]     = a[k][DW-1:0];
            req_b[DW*k +: DW]     = b[k][DW-1:0];
        end
    endtask

    task automatic new_req(input int k);
        v[k]  = 1;
        op[k] = $urandom_range(0, 3);
        a[k]  = $urandom_range(0, 7);
        b[k]  = $urandom_range(0, 7);
    endtask

    // Reference: round-robin search from the model pointer, one response slot.
    always @(negedge clk) begin
        int win;
        int can;
        int exp_rdy;
        int k;
        if (rst) begin
            chk("ready_in_reset", int'(req_ready), 0);
            m_full  = 0;
            m_ptr   = 0;
            m_stall = 0;
            exp_q.delete();
        end else begin
            chk("rsp_valid", int'(rsp_valid), m_full);
`ifdef LU_ARBITER_STALL_CNT_EN
            chk("stall_cnt", int'(stall_cnt), m_stall);
            if (m_full != 0 && !rsp_ready && m_stall < 65535) m_stall++;
`endif
            can = (m_full == 0 || rsp_ready) ? 1 : 0;
            win = -1;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (win < 0 && req_valid[k]) win = k;
            end
            exp_rdy = (win >= 0 && can != 0) ? (1 << win) : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            if (exp_rdy != 0) begin
                exp_q.push_back('{id: win,
                                  data: ref_op(int'(req_op[2*win +: 2]),
                                               int'(req_a[DW*win +: DW]),
                                               int'(req_b[DW*win +: DW]))});
                m_ptr  = (win + 1) % N;
                m_full = 1;
            end else if (m_full != 0 && rsp_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: whatever is presented must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", int'(rsp_id), exp_q[0].id);
                chk("rsp_data", int'(rsp_data), exp_q[0].data);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of requester behaviour; granted requesters retire or reissue.
    task automatic step(input int drop_pct, input int new_pct);
        logic [N-1:0] g;
        @(negedge clk);
        g = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (g[k]) begin
                if ($urandom_range(0, 99) < drop_pct) v[k] = 0;
                else new_req(k);
            end else if (v[k] == 0 && $urandom_range(0, 99) < new_pct) begin
                new_req(k);
            end
        end
        pack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int dops[4];
        int dexp[4];
        dops = '{1, 3, 0, 2};
        dexp = '{2, 5, 0, 7};

        rst       = 1'b1;
        rsp_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            v[k] = 0; op[k] = 0; a[k] = 0; b[k] = 0;
        end
        pack();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_id", int'(rsp_id), 0);
        chk("reset_data", int'(rsp_data), 0);

        // Single requests on requester 0, a=110 b=011
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            v[0] = 1; op[0] = dops[t]; a[0] = 6; b[0] = 3;
            pack();
            @(posedge clk);
            #1;
            v[0] = 0;
            pack();
            @(negedge clk);
            chk("dir_valid", int'(rsp_valid), 1);
            chk("dir_id", int'(rsp_id), 0);
            chk("dir_data", int'(rsp_data), dexp[t]);
        end

        // All requesters continuously valid
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) new_req(k);
        pack();
        repeat (12) step(0, 100);

        // Backpressure while full, then release
        rsp_ready = 1'b0;
        repeat (10) step(0, 100);
        rsp_ready = 1'b1;
        repeat (6) step(0, 100);

        // Randomized traffic
        repeat (1500) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            step(40, 50);
        end

        // Reset while a response is pending
        for (int k = 0; k < N; k++) if (v[k] == 0) new_req(k);
        pack();
        rsp_ready = 1'b0;
        repeat (3) step(0, 100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_id", int'(rsp_id), 0);
        chk("midrst_data", int'(rsp_data), 0);
        rsp_ready = 1'b1;
        repeat (8) step(0, 100);

        // Drain
        for (int k = 0; k < N; k++) v[k] = 0;
        pack();
        repeat (4) step(100, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lu_arbiter

`default_nettype wire
